// File: rtl/ex_mem_stage_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Package : ex_mem_stage_pkg                                         |
// | Purpose : Shared definitions for the execute stage and EX/MEM      |
// |           register: datapath width default, ALU op codes and the   |
// |           iterative multiplier state codes.                        |
// | Rev     : 1.0  initial release                                     |
// +--------------------------------------------------------------------+
package ex_mem_stage_pkg;

   localparam int DEFAULT_DATA_W = 32;

   typedef enum logic [3:0] {
      ALU_ADD  = 4'd0,
      ALU_SUB  = 4'd1,
      ALU_AND  = 4'd2,
      ALU_OR   = 4'd3,
      ALU_XOR  = 4'd4,
      ALU_NOR  = 4'd5,
      ALU_SLT  = 4'd6,
      ALU_SLTU = 4'd7,
      ALU_SLL  = 4'd8,
      ALU_SRL  = 4'd9,
      ALU_SRA  = 4'd10,
      ALU_LUI  = 4'd11,
      ALU_MUL  = 4'd12
   } alu_op_e;

   typedef enum logic [1:0] {
      MUL_IDLE = 2'd0,
      MUL_RUN  = 2'd1,
      MUL_DONE = 2'd2
   } mul_state_e;

endpackage
`default_nettype wire

// File: rtl/ex_multiplier.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module  : ex_multiplier                                            |
// | Purpose : Iterative shift-add multiplier, one partial product per  |
// |           cycle, DATA_W iterations. Returns the low DATA_W bits.   |
// | Ports   : clk, rst       clock / sync active-high reset            |
// |           start_i        issue request (sampled in IDLE only)      |
// |           accept_i       downstream takes the product in DONE      |
// |           a_i, b_i       operands (multiplicand, multiplier)       |
// |           busy_o         combinational stall request               |
// |           done_o         product_o is valid                        |
// |           product_o      accumulator                               |
// | Rev     : 1.0  initial release                                     |
// +--------------------------------------------------------------------+
module ex_multiplier
   import ex_mem_stage_pkg::*;
#(
   parameter int DATA_W = DEFAULT_DATA_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start_i,
   input  logic              accept_i,
   input  logic [DATA_W-1:0] a_i,
   input  logic [DATA_W-1:0] b_i,
   output logic              busy_o,
   output logic              done_o,
   output logic [DATA_W-1:0] product_o
);

   localparam int CNT_W = $clog2(DATA_W);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

   mul_state_e        state_q, state_d;
   logic [DATA_W-1:0] acc_q, acc_d;
   logic [DATA_W-1:0] mcand_q, mcand_d;
   logic [DATA_W-1:0] mplier_q, mplier_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= MUL_IDLE;
         acc_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         acc_q    <= acc_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         cnt_q    <= cnt_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      acc_d    = acc_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      cnt_d    = cnt_q;
      busy_o   = 1'b0;
      done_o   = 1'b0;
      case (state_q)
         MUL_IDLE: begin
            // Stall must rise in the issue cycle itself so the instruction
            // behind the MUL does not advance.
            if (start_i) begin
               busy_o   = 1'b1;
               mcand_d  = a_i;
               mplier_d = b_i;
               acc_d    = '0;
               cnt_d    = '0;
               state_d  = MUL_RUN;
            end
         end
         MUL_RUN: begin
            busy_o = 1'b1;
            if (mcand_q[0]) begin
               acc_d = acc_q + mplier_q;
            end
            mcand_d  = mcand_q >> 1;
            mplier_d = mplier_q << 1;
            cnt_d    = cnt_q + 1'b1;
            if (cnt_q == CNT_LAST) begin
               state_d = MUL_DONE;
            end
         end
         MUL_DONE: begin
            done_o = 1'b1;
            if (accept_i) begin
               state_d = MUL_IDLE;
            end
         end
         default: begin
            state_d = MUL_IDLE;
         end
      endcase
      // Nothing may issue or hold the pipeline while reset is applied.
      if (rst) begin
         busy_o = 1'b0;
      end
   end

   assign product_o = acc_q;

endmodule
`default_nettype wire

// File: rtl/ex_mem_stage.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module  : ex_mem_stage                                             |
// | Purpose : Execute stage (operand select, ALU, iterative MUL) plus  |
// |           the EX/MEM pipeline register.                            |
// | Ports   : ex_*   resolved ID/EX fields (operands and control)      |
// |           mem_stall  hold the EX/MEM register                      |
// |           ex_stall   upstream hold while a MUL is in flight        |
// |           mem_*  registered result, store data and control         |
// | Rev     : 1.0  initial release                                     |
// +--------------------------------------------------------------------+
module ex_mem_stage
   import ex_mem_stage_pkg::*;
#(
   parameter int DATA_W = DEFAULT_DATA_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] ex_shiftAmount,
   input  logic [DATA_W-1:0] ex_immediate,
   input  logic [DATA_W-1:0] ex_registerRsOrPc_4,
   input  logic [DATA_W-1:0] ex_registerRtOrZero,
   input  logic [3:0]        ex_aluOperation,
   input  logic [4:0]        ex_registerWriteBackDestination,
   input  logic              ex_ifWriteRegsFile,
   input  logic              ex_ifWriteMem,
   input  logic              ex_whileShiftAluInput_A_UseShamt,
   input  logic              ex_memOutOrAluOutWriteBackToRegFile,
   input  logic              ex_aluInput_B_UseRtOrImmeidate,
   input  logic              mem_stall,
   output logic              ex_stall,
   output logic [DATA_W-1:0] mem_aluOut,
   output logic [DATA_W-1:0] mem_storeData,
   output logic [4:0]        mem_registerWriteBackDestination,
   output logic              mem_ifWriteRegsFile,
   output logic              mem_ifWriteMem,
   output logic              mem_memOutOrAluOutWriteBackToRegFile
);

   localparam int SH_W = $clog2(DATA_W);

   logic [DATA_W-1:0] op_a, op_b, alu_result, mul_product;
   logic              mul_issue, mul_done;

   assign op_a = ex_whileShiftAluInput_A_UseShamt ? ex_shiftAmount : ex_registerRsOrPc_4;
   assign op_b = ex_aluInput_B_UseRtOrImmeidate   ? ex_immediate   : ex_registerRtOrZero;

   // A zeroed ID/EX bubble carries no write enable, so it never starts a MUL.
   assign mul_issue = (ex_aluOperation == ALU_MUL) && (ex_ifWriteRegsFile || ex_ifWriteMem);

   ex_multiplier #(
      .DATA_W (DATA_W)
   ) u_mul (
      .clk       (clk),
      .rst       (rst),
      .start_i   (mul_issue),
      .accept_i  (!mem_stall),
      .a_i       (op_a),
      .b_i       (op_b),
      .busy_o    (ex_stall),
      .done_o    (mul_done),
      .product_o (mul_product)
   );

   always_comb begin
      alu_result = '0;
      case (ex_aluOperation)
         ALU_ADD:  alu_result = op_a + op_b;
         ALU_SUB:  alu_result = op_a - op_b;
         ALU_AND:  alu_result = op_a & op_b;
         ALU_OR:   alu_result = op_a | op_b;
         ALU_XOR:  alu_result = op_a ^ op_b;
         ALU_NOR:  alu_result = ~(op_a | op_b);
         ALU_SLT:  alu_result = {{(DATA_W-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
         ALU_SLTU: alu_result = {{(DATA_W-1){1'b0}}, (op_a < op_b)};
         ALU_SLL:  alu_result = op_b << op_a[SH_W-1:0];
         ALU_SRL:  alu_result = op_b >> op_a[SH_W-1:0];
         ALU_SRA:  alu_result = $signed(op_b) >>> op_a[SH_W-1:0];
         ALU_LUI:  alu_result = op_b << 16;
         ALU_MUL:  alu_result = mul_done ? mul_product : '0;
         default:  alu_result = '0;
      endcase
   end

   logic [DATA_W-1:0] alu_out_q, store_data_q;
   logic [4:0]        dest_q;
   logic              wr_reg_q, wr_mem_q, wb_sel_q;

   // Priority: mem_stall holds everything; a stall inserts a bubble by
   // clearing only the write enables; otherwise capture.
   always_ff @(posedge clk) begin
      if (rst) begin
         alu_out_q    <= '0;
         store_data_q <= '0;
         dest_q       <= '0;
         wr_reg_q     <= 1'b0;
         wr_mem_q     <= 1'b0;
         wb_sel_q     <= 1'b0;
      end else if (!mem_stall) begin
         if (ex_stall) begin
            wr_reg_q <= 1'b0;
            wr_mem_q <= 1'b0;
         end else begin
            alu_out_q    <= alu_result;
            store_data_q <= ex_registerRtOrZero;
            dest_q       <= ex_registerWriteBackDestination;
            wr_reg_q     <= ex_ifWriteRegsFile;
            wr_mem_q     <= ex_ifWriteMem;
            wb_sel_q     <= ex_memOutOrAluOutWriteBackToRegFile;
         end
      end
   end

   assign mem_aluOut                           = alu_out_q;
   assign mem_storeData                        = store_data_q;
   assign mem_registerWriteBackDestination     = dest_q;
   assign mem_ifWriteRegsFile                  = wr_reg_q;
   assign mem_ifWriteMem                       = wr_mem_q;
   assign mem_memOutOrAluOutWriteBackToRegFile = wb_sel_q;

endmodule
`default_nettype wire

// File: tb/tb_ex_mem_stage.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module  : tb_ex_mem_stage                                          |
// | Purpose : Directed self-checking bench for ex_mem_stage.           |
// | Rev     : 1.0  initial release                                     |
// +--------------------------------------------------------------------+
module tb_ex_mem_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] shamt, imm, rs, rt;
   logic [3:0]  op;
   logic [4:0]  dest;
   logic        wen, wmem, use_shamt, wb_sel, use_imm, mstall;
   logic        ex_stall;
   logic [31:0] m_alu, m_store;
   logic [4:0]  m_dest;
   logic        m_wen, m_wmem, m_wb_sel;

   int n_checks = 0;
   int n_errors = 0;
   int n;

   always #5 clk = ~clk;

   ex_mem_stage dut (
      .clk                                  (clk),
      .rst                                  (rst),
      .ex_shiftAmount                       (shamt),
      .ex_immediate                         (imm),
      .ex_registerRsOrPc_4                  (rs),
      .ex_registerRtOrZero                  (rt),
      .ex_aluOperation                      (op),
      .ex_registerWriteBackDestination      (dest),
      .ex_ifWriteRegsFile                   (wen),
      .ex_ifWriteMem                        (wmem),
      .ex_whileShiftAluInput_A_UseShamt     (use_shamt),
      .ex_memOutOrAluOutWriteBackToRegFile  (wb_sel),
      .ex_aluInput_B_UseRtOrImmeidate       (use_imm),
      .mem_stall                            (mstall),
      .ex_stall                             (ex_stall),
      .mem_aluOut                           (m_alu),
      .mem_storeData                        (m_store),
      .mem_registerWriteBackDestination     (m_dest),
      .mem_ifWriteRegsFile                  (m_wen),
      .mem_ifWriteMem                       (m_wmem),
      .mem_memOutOrAluOutWriteBackToRegFile (m_wb_sel)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      shamt = '0; imm = '0; rs = '0; rt = '0; op = '0; dest = '0;
      wen = 1'b0; wmem = 1'b0; use_shamt = 1'b0; wb_sel = 1'b0; use_imm = 1'b0;
   endtask

   // Register-register op with wen=1; A=rs, B=rt.
   task automatic drive_rr(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                           input logic [4:0] d);
      clear_inputs();
      op = o; rs = a; rt = b; dest = d; wen = 1'b1;
   endtask

   // Count the cycles ex_stall stays high, bounded.
   task automatic count_stall(output int cycles);
      cycles = 0;
      #1;
      while (ex_stall === 1'b1 && cycles < 100) begin
         cycles++;
         tick();
      end
   endtask

   initial begin
      rst = 1'b1; mstall = 1'b0;
      clear_inputs();
      tick(); tick();
      check("reset aluOut", m_alu, 32'h0);
      check("reset wen",    {31'b0, m_wen}, 32'h0);
      check("reset wmem",   {31'b0, m_wmem}, 32'h0);
      check("reset dest",   {27'b0, m_dest}, 32'h0);
      check("reset stall",  {31'b0, ex_stall}, 32'h0);
      rst = 1'b0;

      // ADD A=5 + imm 7
      clear_inputs();
      op = 4'd0; rs = 32'd5; imm = 32'd7; use_imm = 1'b1; wen = 1'b1; dest = 5'd3;
      #1 check("add stall", {31'b0, ex_stall}, 32'h0);
      tick();
      check("add result", m_alu, 32'd12);
      check("add wen",    {31'b0, m_wen}, 32'h1);
      check("add dest",   {27'b0, m_dest}, 32'd3);

      drive_rr(4'd1, 32'd3, 32'd5, 5'd4);            tick(); check("sub wrap", m_alu, 32'hFFFF_FFFE);
      drive_rr(4'd6, 32'hFFFF_FFFF, 32'd1, 5'd5);   tick(); check("slt",  m_alu, 32'd1);
      drive_rr(4'd7, 32'hFFFF_FFFF, 32'd1, 5'd6);   tick(); check("sltu", m_alu, 32'd0);
      drive_rr(4'd5, 32'h0F0F_0000, 32'h0000_00F0, 5'd7); tick(); check("nor", m_alu, 32'hF0F0_FF0F);
      drive_rr(4'd13, 32'h1234, 32'h5678, 5'd8);    tick(); check("op13 zero", m_alu, 32'd0);
      clear_inputs(); op = 4'd11; imm = 32'h0000_1234; use_imm = 1'b1; wen = 1'b1;
      tick(); check("lui", m_alu, 32'h1234_0000);

      // SRA shamt=4 on 0x80000000, store data is rt
      clear_inputs();
      op = 4'd10; shamt = 32'd4; use_shamt = 1'b1; rt = 32'h8000_0000; wen = 1'b1; wmem = 1'b1;
      dest = 5'd9; wb_sel = 1'b1;
      tick();
      check("sra",       m_alu, 32'hF800_0000);
      check("sra store", m_store, 32'h8000_0000);
      check("sra wbsel", {31'b0, m_wb_sel}, 32'h1);

      // mem_stall holds EX/MEM for three cycles
      mstall = 1'b1;
      drive_rr(4'd0, 32'd1, 32'd1, 5'd10);
      for (int i = 0; i < 3; i++) begin
         tick();
         check("hold aluOut", m_alu, 32'hF800_0000);
         check("hold wmem",   {31'b0, m_wmem}, 32'h1);
         check("hold dest",   {27'b0, m_dest}, 32'd9);
      end
      mstall = 1'b0;
      tick();
      check("resume result", m_alu, 32'd2);
      check("resume dest",   {27'b0, m_dest}, 32'd10);

      // MUL 0x00010003 * 5
      drive_rr(4'd12, 32'h0001_0003, 32'd5, 5'd11);
      count_stall(n);
      check("mul stall cycles", n, 32'd33);
      check("mul bubble wen", {31'b0, m_wen}, 32'h0);
      tick();
      check("mul result", m_alu, 32'h0005_000F);
      check("mul wen",    {31'b0, m_wen}, 32'h1);
      drive_rr(4'd0, 32'd1, 32'd2, 5'd12);
      #1 check("after mul stall", {31'b0, ex_stall}, 32'h0);
      tick();
      check("after mul result", m_alu, 32'd3);

      // Reset mid-RUN, then the same MUL restarts
      drive_rr(4'd12, 32'hFFFF_FFFF, 32'd3, 5'd13);
      repeat (10) tick();
      check("midrun stall", {31'b0, ex_stall}, 32'h1);
      rst = 1'b1;
      tick();
      check("rst aluOut", m_alu, 32'h0);
      check("rst store",  m_store, 32'h0);
      check("rst dest",   {27'b0, m_dest}, 32'h0);
      check("rst stall",  {31'b0, ex_stall}, 32'h0);
      rst = 1'b0;
      count_stall(n);
      check("remul stall cycles", n, 32'd33);
      tick();
      check("remul result", m_alu, 32'hFFFF_FFFD);
      check("remul dest",   {27'b0, m_dest}, 32'd13);

      // All-zero ID/EX carrying op=12 must not start the multiplier
      clear_inputs(); op = 4'd12;
      #1 check("bubble mul stall", {31'b0, ex_stall}, 32'h0);
      tick();
      check("bubble wen",  {31'b0, m_wen}, 32'h0);
      check("bubble wmem", {31'b0, m_wmem}, 32'h0);
      check("bubble stall after", {31'b0, ex_stall}, 32'h0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
